// File: rtl/msrv32_branch_predict_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msrv32_branch_predict_unit_if                                              |
// | Fetch-lookup, execute-resolve and statistics signals of the predict unit.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface msrv32_branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  fetch_pc_in;
    logic             predict_taken_out;
    logic             resolve_valid_in;
    logic [XLEN-1:0]  resolve_pc_in;
    logic [XLEN-1:0]  rs_1_in;
    logic [XLEN-1:0]  rs_2_in;
    logic [4:0]       opcode_in;
    logic [2:0]       funct3_in;
    logic             pred_taken_in;
    logic             flush_in;
    logic             stats_clr_in;
    logic             resolve_valid_out;
    logic             branch_taken_out;
    logic             mispredict_out;
    logic [CNT_W-1:0] branch_count_out;
    logic [CNT_W-1:0] mispredict_count_out;

    modport master (
        output fetch_pc_in, resolve_valid_in, resolve_pc_in, rs_1_in, rs_2_in,
               opcode_in, funct3_in, pred_taken_in, flush_in, stats_clr_in,
        input  predict_taken_out, resolve_valid_out, branch_taken_out,
               mispredict_out, branch_count_out, mispredict_count_out
    );

    modport slave (
        input  fetch_pc_in, resolve_valid_in, resolve_pc_in, rs_1_in, rs_2_in,
               opcode_in, funct3_in, pred_taken_in, flush_in, stats_clr_in,
        output predict_taken_out, resolve_valid_out, branch_taken_out,
               mispredict_out, branch_count_out, mispredict_count_out
    );
endinterface
`default_nettype wire

// File: rtl/msrv32_branch_predict_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | msrv32_branch_predict_unit                                                 |
// | Branch/jump resolution, mispredict flagging, 2-bit BHT and statistics.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module msrv32_branch_predict_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2,
    parameter int CNT_W     = 32
) (
    input  logic                          ms_riscv32_mp_clk_in,
    input  logic                          ms_riscv32_mp_rst_in,
    msrv32_branch_predict_unit_if.slave   bus
);
    localparam int               c_idx_w     = $clog2(BHT_DEPTH);
    localparam logic [4:0]       c_op_branch = 5'b11000;
    localparam logic [4:0]       c_op_jal    = 5'b11011;
    localparam logic [4:0]       c_op_jalr   = 5'b11001;
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [1:0]         r_bht [BHT_DEPTH];
    logic [c_idx_w-1:0] w_fetch_idx;
    logic [c_idx_w-1:0] w_res_idx;
    logic               w_is_jump;
    logic               w_legal_br;
    logic               w_cond;
    logic               w_taken;
    logic               w_mispred;
    logic               w_accept;
    logic               w_unused_pc_bits;
    logic               r_valid;
    logic               r_taken;
    logic               r_mispred;
    logic [CNT_W-1:0]   r_br_cnt;
    logic [CNT_W-1:0]   r_mp_cnt;

    assign w_fetch_idx      = bus.fetch_pc_in[IDX_LSB +: c_idx_w];
    assign w_res_idx        = bus.resolve_pc_in[IDX_LSB +: c_idx_w];
    assign w_unused_pc_bits = ^{bus.fetch_pc_in, bus.resolve_pc_in};

    assign w_is_jump  = (bus.opcode_in == c_op_jal) || (bus.opcode_in == c_op_jalr);
    // funct3 010/011 are not defined branch conditions
    assign w_legal_br = (bus.opcode_in == c_op_branch) && (bus.funct3_in[2:1] != 2'b01);

    always_comb begin
        w_cond = 1'b0;
        case (bus.funct3_in)
            3'b000:  w_cond = (bus.rs_1_in == bus.rs_2_in);
            3'b001:  w_cond = (bus.rs_1_in != bus.rs_2_in);
            3'b100:  w_cond = ($signed(bus.rs_1_in) <  $signed(bus.rs_2_in));
            3'b101:  w_cond = ($signed(bus.rs_1_in) >= $signed(bus.rs_2_in));
            3'b110:  w_cond = (bus.rs_1_in <  bus.rs_2_in);
            3'b111:  w_cond = (bus.rs_1_in >= bus.rs_2_in);
            default: w_cond = 1'b0;
        endcase
    end

    // Non-control and illegal resolve as not-taken, so a mispredict is always taken ^ guess
    assign w_taken   = w_is_jump | (w_legal_br & w_cond);
    assign w_mispred = w_taken ^ bus.pred_taken_in;
    assign w_accept  = bus.resolve_valid_in & ~bus.flush_in;

    assign bus.predict_taken_out    = r_bht[w_fetch_idx][1];
    assign bus.resolve_valid_out    = r_valid;
    assign bus.branch_taken_out     = r_taken;
    assign bus.mispredict_out       = r_mispred;
    assign bus.branch_count_out     = r_br_cnt;
    assign bus.mispredict_count_out = r_mp_cnt;

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_mispred <= 1'b0;
        end else begin
            r_valid   <= w_accept;
            r_taken   <= w_accept & w_taken;
            r_mispred <= w_accept & w_mispred;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else if (bus.stats_clr_in) begin
            r_br_cnt <= '0;
            r_mp_cnt <= '0;
        end else if (w_accept) begin
            if (w_legal_br && (r_br_cnt != c_cnt_max)) begin
                r_br_cnt <= r_br_cnt + c_cnt_one;
            end
            if (w_mispred && (r_mp_cnt != c_cnt_max)) begin
                r_mp_cnt <= r_mp_cnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept && w_legal_br) begin
            if (w_taken && (r_bht[w_res_idx] != 2'b11)) begin
                r_bht[w_res_idx] <= r_bht[w_res_idx] + 2'b01;
            end else if (!w_taken && (r_bht[w_res_idx] != 2'b00)) begin
                r_bht[w_res_idx] <= r_bht[w_res_idx] - 2'b01;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_msrv32_branch_predict_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_msrv32_branch_predict_unit                                              |
// | Directed self-checking bench for the branch predict unit (CNT_W=4).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_msrv32_branch_predict_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    msrv32_branch_predict_unit_if #(.XLEN(32), .CNT_W(4)) bus ();

    msrv32_branch_predict_unit #(
        .XLEN(32), .BHT_DEPTH(64), .IDX_LSB(2), .CNT_W(4)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus)
    );

    task automatic setup(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic pred,
                         input logic flush, input logic clr);
        bus.resolve_valid_in = 1'b1;
        bus.opcode_in        = op;
        bus.funct3_in        = f3;
        bus.rs_1_in          = a;
        bus.rs_2_in          = b;
        bus.resolve_pc_in    = pc;
        bus.pred_taken_in    = pred;
        bus.flush_in         = flush;
        bus.stats_clr_in     = clr;
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
        bus.resolve_valid_in = 1'b0;
        bus.flush_in         = 1'b0;
        bus.stats_clr_in     = 1'b0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic pred,
                         input logic flush, input logic clr);
        setup(op, f3, a, b, pc, pred, flush, clr);
        commit();
    endtask

    task automatic do_reset();
        bus.resolve_valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] pcs [3];
        pcs = '{32'h0, 32'h100, 32'hFFFF_FFFC};
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.fetch_pc_in = pcs[i];
            #1;
            checks++; if (bus.predict_taken_out !== 1'b0) begin failures++; $display("FAIL reset_predict pc=%h got=%b exp=0", pcs[i], bus.predict_taken_out); end
        end
        checks++; if ({bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out} !== 3'b000) begin failures++; $display("FAIL reset_outputs got=%b exp=000", {bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out}); end
        checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'h00) begin failures++; $display("FAIL reset_counts got=%h exp=00", {bus.branch_count_out, bus.mispredict_count_out}); end
        rst = 1'b0;
    endtask

    task automatic test_compare();
        logic [4:0]  ops  [8];
        logic [2:0]  f3s  [8];
        logic [31:0] as   [8];
        logic [31:0] bs   [8];
        logic        prd  [8];
        logic        et   [8];
        logic        em   [8];
        ops = '{5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b11000, 5'b01100};
        f3s = '{3'b100, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111, 3'b010, 3'b000};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd1, 32'd1, 32'd3, 32'd0};
        bs  = '{32'd1, 32'd1, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd0};
        prd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        et  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        em  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], f3s[i], as[i], bs[i], 32'h10, prd[i], 1'b0, 1'b0);
            checks++; if (bus.resolve_valid_out !== 1'b1) begin failures++; $display("FAIL cmp_valid[%0d] got=%b exp=1", i, bus.resolve_valid_out); end
            checks++; if (bus.branch_taken_out !== et[i]) begin failures++; $display("FAIL cmp_taken[%0d] got=%b exp=%b", i, bus.branch_taken_out, et[i]); end
            checks++; if (bus.mispredict_out !== em[i]) begin failures++; $display("FAIL cmp_mispred[%0d] got=%b exp=%b", i, bus.mispredict_out, em[i]); end
        end
        checks++; if (bus.branch_count_out !== 4'd6) begin failures++; $display("FAIL cmp_branch_count got=%0d exp=6", bus.branch_count_out); end
        checks++; if (bus.mispredict_count_out !== 4'd4) begin failures++; $display("FAIL cmp_mispred_count got=%0d exp=4", bus.mispredict_count_out); end
        @(posedge clk);
        #1;
        checks++; if ({bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out} !== 3'b000) begin failures++; $display("FAIL idle_outputs got=%b exp=000", {bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out}); end
    endtask

    task automatic test_bht();
        logic exp_up [3];
        logic exp_dn [3];
        exp_up = '{1'b1, 1'b1, 1'b1};
        exp_dn = '{1'b1, 1'b0, 1'b0};
        do_reset();
        bus.fetch_pc_in = 32'h100;
        setup(5'b11000, 3'b000, 32'd7, 32'd7, 32'h100, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.predict_taken_out !== 1'b0) begin failures++; $display("FAIL bht_same_cycle got=%b exp=0", bus.predict_taken_out); end
        commit();
        checks++; if (bus.predict_taken_out !== exp_up[0]) begin failures++; $display("FAIL bht_inc[0] got=%b exp=1", bus.predict_taken_out); end
        for (int i = 1; i < 3; i++) begin
            drive(5'b11000, 3'b000, 32'd7, 32'd7, 32'h100, 1'b1, 1'b0, 1'b0);
            checks++; if (bus.predict_taken_out !== exp_up[i]) begin failures++; $display("FAIL bht_inc[%0d] got=%b exp=%b", i, bus.predict_taken_out, exp_up[i]); end
        end
        bus.fetch_pc_in = 32'h200;
        #1;
        checks++; if (bus.predict_taken_out !== 1'b1) begin failures++; $display("FAIL bht_alias got=%b exp=1", bus.predict_taken_out); end
        bus.fetch_pc_in = 32'h104;
        #1;
        checks++; if (bus.predict_taken_out !== 1'b0) begin failures++; $display("FAIL bht_neighbour got=%b exp=0", bus.predict_taken_out); end
        bus.fetch_pc_in = 32'h100;
        for (int i = 0; i < 3; i++) begin
            drive(5'b11000, 3'b001, 32'd7, 32'd7, 32'h100, 1'b1, 1'b0, 1'b0);
            checks++; if (bus.predict_taken_out !== exp_dn[i]) begin failures++; $display("FAIL bht_dec[%0d] got=%b exp=%b", i, bus.predict_taken_out, exp_dn[i]); end
        end
        // From a saturated 00, one taken update must land on 01 (still not-taken)
        drive(5'b11000, 3'b000, 32'd7, 32'd7, 32'h100, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.predict_taken_out !== 1'b0) begin failures++; $display("FAIL bht_floor got=%b exp=0", bus.predict_taken_out); end
        drive(5'b11000, 3'b000, 32'd7, 32'd7, 32'h100, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.predict_taken_out !== 1'b1) begin failures++; $display("FAIL bht_recover got=%b exp=1", bus.predict_taken_out); end
        // Illegal funct3 leaves the entry alone
        drive(5'b11000, 3'b011, 32'd7, 32'd7, 32'h100, 1'b0, 1'b0, 1'b0);
        drive(5'b11000, 3'b010, 32'd7, 32'd7, 32'h100, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.predict_taken_out !== 1'b1) begin failures++; $display("FAIL bht_illegal got=%b exp=1", bus.predict_taken_out); end
    endtask

    task automatic test_jump();
        do_reset();
        bus.fetch_pc_in = 32'h100;
        drive(5'b11011, 3'b000, 32'd0, 32'd0, 32'h100, 1'b0, 1'b0, 1'b0);
        checks++; if ({bus.branch_taken_out, bus.mispredict_out} !== 2'b11) begin failures++; $display("FAIL jal_result got=%b exp=11", {bus.branch_taken_out, bus.mispredict_out}); end
        checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'h01) begin failures++; $display("FAIL jal_counts got=%h exp=01", {bus.branch_count_out, bus.mispredict_count_out}); end
        checks++; if (bus.predict_taken_out !== 1'b0) begin failures++; $display("FAIL jal_bht got=%b exp=0", bus.predict_taken_out); end
        drive(5'b11001, 3'b000, 32'd0, 32'd0, 32'h100, 1'b1, 1'b0, 1'b0);
        checks++; if ({bus.branch_taken_out, bus.mispredict_out} !== 2'b10) begin failures++; $display("FAIL jalr_result got=%b exp=10", {bus.branch_taken_out, bus.mispredict_out}); end
        checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'h01) begin failures++; $display("FAIL jalr_counts got=%h exp=01", {bus.branch_count_out, bus.mispredict_count_out}); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.fetch_pc_in = 32'h100;
        drive(5'b11011, 3'b000, 32'd0, 32'd0, 32'h100, 1'b0, 1'b0, 1'b0);
        drive(5'b11000, 3'b001, 32'd1, 32'd2, 32'h100, 1'b0, 1'b1, 1'b0);
        checks++; if ({bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out} !== 3'b000) begin failures++; $display("FAIL flush_outputs got=%b exp=000", {bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out}); end
        checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'h01) begin failures++; $display("FAIL flush_counts got=%h exp=01", {bus.branch_count_out, bus.mispredict_count_out}); end
        drive(5'b11000, 3'b001, 32'd1, 32'd2, 32'h100, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.predict_taken_out !== 1'b0) begin failures++; $display("FAIL flush_bht got=%b exp=0", bus.predict_taken_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs = '{32'h0, 32'h4, 32'h8};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'b11000, 3'b000, 32'd9, 32'd9, pcs[i], 1'b1, 1'b0, 1'b0);
            checks++; if ({bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out} !== 3'b110) begin failures++; $display("FAIL b2b_result[%0d] got=%b exp=110", i, {bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out}); end
        end
        for (int i = 0; i < 3; i++) begin
            bus.fetch_pc_in = pcs[i];
            #1;
            checks++; if (bus.predict_taken_out !== 1'b1) begin failures++; $display("FAIL b2b_predict[%0d] got=%b exp=1", i, bus.predict_taken_out); end
        end
        bus.fetch_pc_in = 32'hC;
        #1;
        checks++; if (bus.predict_taken_out !== 1'b0) begin failures++; $display("FAIL b2b_untouched got=%b exp=0", bus.predict_taken_out); end
        checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'h30) begin failures++; $display("FAIL b2b_counts got=%h exp=30", {bus.branch_count_out, bus.mispredict_count_out}); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(5'b11000, 3'b001, 32'd1, 32'd2, 32'h300, 1'b0, 1'b0, 1'b0);
            if (i == 13) begin
                checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'hEE) begin failures++; $display("FAIL sat_mid got=%h exp=ee", {bus.branch_count_out, bus.mispredict_count_out}); end
            end
        end
        checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'hFF) begin failures++; $display("FAIL sat_counts got=%h exp=ff", {bus.branch_count_out, bus.mispredict_count_out}); end
        drive(5'b11000, 3'b001, 32'd1, 32'd2, 32'h300, 1'b0, 1'b0, 1'b1);
        checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'h00) begin failures++; $display("FAIL clr_counts got=%h exp=00", {bus.branch_count_out, bus.mispredict_count_out}); end
        checks++; if (bus.mispredict_out !== 1'b1) begin failures++; $display("FAIL clr_result got=%b exp=1", bus.mispredict_out); end
        drive(5'b11000, 3'b001, 32'd1, 32'd2, 32'h300, 1'b0, 1'b0, 1'b0);
        checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'h11) begin failures++; $display("FAIL post_clr_counts got=%h exp=11", {bus.branch_count_out, bus.mispredict_count_out}); end
        bus.fetch_pc_in = 32'h300;
        #1;
        checks++; if (bus.predict_taken_out !== 1'b1) begin failures++; $display("FAIL pre_rst_predict got=%b exp=1", bus.predict_taken_out); end
        // Asynchronous reset well away from any clock edge
        #1;
        rst = 1'b1;
        #1;
        checks++; if ({bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out} !== 3'b000) begin failures++; $display("FAIL async_rst_outputs got=%b exp=000", {bus.resolve_valid_out, bus.branch_taken_out, bus.mispredict_out}); end
        checks++; if ({bus.branch_count_out, bus.mispredict_count_out} !== 8'h00) begin failures++; $display("FAIL async_rst_counts got=%h exp=00", {bus.branch_count_out, bus.mispredict_count_out}); end
        checks++; if (bus.predict_taken_out !== 1'b0) begin failures++; $display("FAIL async_rst_bht got=%b exp=0", bus.predict_taken_out); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Entry is back at weak not-taken: one taken update flips the prediction
        drive(5'b11000, 3'b000, 32'd1, 32'd1, 32'h300, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.predict_taken_out !== 1'b1) begin failures++; $display("FAIL rst_weak_nt got=%b exp=1", bus.predict_taken_out); end
    endtask

    initial begin
        bus.fetch_pc_in      = '0;
        bus.resolve_valid_in = 1'b0;
        bus.resolve_pc_in    = '0;
        bus.rs_1_in          = '0;
        bus.rs_2_in          = '0;
        bus.opcode_in        = '0;
        bus.funct3_in        = '0;
        bus.pred_taken_in    = 1'b0;
        bus.flush_in         = 1'b0;
        bus.stats_clr_in     = 1'b0;
        test_reset();
        test_compare();
        test_bht();
        test_jump();
        test_flush();
        test_back_to_back();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
